boot_sequencer: RTL and testbench

//  Load controller for the single-cycle RISC-V core. Holds the CPU in reset and clears x1..x31.

---
 rtl/boot_seq_pkg.sv | 22 ++
 rtl/boot_beat_cnt.sv | 36 +++
 rtl/boot_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_boot_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_seq_pkg.sv
// Shared definitions for the boot sequencer: state encoding, register-file clear
// bound and the image-header legality check.
package boot_seq_pkg;

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] CLR_RF  = 4'd1;
   localparam logic [3:0] HDR_I   = 4'd2;
   localparam logic [3:0] LOAD_I  = 4'd3;
   localparam logic [3:0] HDR_D   = 4'd4;
   localparam logic [3:0] LOAD_D  = 4'd5;
   localparam logic [3:0] RELEASE = 4'd6;
   localparam logic [3:0] RUN     = 4'd7;
   localparam logic [3:0] ERR     = 4'd8;

   localparam logic [4:0] RF_LAST = 5'd31;

   // A word count of exactly 2**aw fills the memory and is still legal.
   function automatic logic hdr_ok(input logic [31:0] n, input int unsigned aw);
      return n <= (32'd1 << aw);
   endfunction

endpackage

// File: rtl/boot_beat_cnt.sv
// Per-memory beat counter: remaining-word down-counter with a parallel up-address.
// last flags the final beat so the address never steps past the top of memory.
module boot_beat_cnt #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [AW:0]   n,
   input  logic          dec,
   output logic [AW-1:0] addr,
   output logic          last
);

   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] ADDR_ONE = 1;

   logic [AW:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         addr <= '0;
      end else if (load) begin
         cnt  <= n;
         addr <= '0;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_ONE;
         if (!last)
            addr <= addr + ADDR_ONE;
      end
   end

   assign last = (cnt == CNT_ONE);

endmodule

// File: rtl/boot_sequencer.sv
// Boot loader for the single-cycle RISC-V core: clears x1..x31, streams the
// IMEM/DMEM image from a valid/ready port and releases the CPU from reset.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, CPU held; waits for start (or autoboot)
// CLR_RF  | writes zero to x1..x31, one register per cycle
// HDR_I   | waits for the IMEM word count
// LOAD_I  | streams IMEM words
// HDR_D   | waits for the DMEM word count
// LOAD_D  | streams DMEM words
// RELEASE | one extra cycle in reset so the final write lands first
// RUN     | CPU running, done=1
// ERR     | oversize header seen; only start leaves
module boot_sequencer
   import boot_seq_pkg::*;
#(
   parameter int IMEM_AW  = 8,
   parameter int DMEM_AW  = 8,
   parameter bit RF_CLEAR = 1'b1,
   parameter bit AUTOBOOT = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               ld_valid,
   input  logic [31:0]        ld_data,
   output logic               ld_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic               rf_we,
   output logic [4:0]         rf_addr,
   output logic [31:0]        wdata,
   output logic               cpu_rst,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [3:0] BOOT_ENTRY = RF_CLEAR ? CLR_RF : HDR_I;

   logic [3:0]         state;
   logic [3:0]         state_nxt;
   logic               xfer;

   logic               i_load;
   logic               i_dec;
   logic [IMEM_AW:0]   i_n;
   logic [IMEM_AW-1:0] i_addr;
   logic               i_last;

   logic               d_load;
   logic               d_dec;
   logic [DMEM_AW:0]   d_n;
   logic [DMEM_AW-1:0] d_addr;
   logic               d_last;

   assign xfer = ld_valid & ld_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (AUTOBOOT || start) state_nxt = BOOT_ENTRY;
         CLR_RF:  if (rf_addr == RF_LAST) state_nxt = HDR_I;
         HDR_I: begin
            if (xfer) begin
               if (!hdr_ok(ld_data, IMEM_AW)) state_nxt = ERR;
               else if (ld_data == '0)        state_nxt = HDR_D;
               else                           state_nxt = LOAD_I;
            end
         end
         LOAD_I:  if (xfer && i_last) state_nxt = HDR_D;
         HDR_D: begin
            if (xfer) begin
               if (!hdr_ok(ld_data, DMEM_AW)) state_nxt = ERR;
               else if (ld_data == '0)        state_nxt = RELEASE;
               else                           state_nxt = LOAD_D;
            end
         end
         LOAD_D:  if (xfer && d_last) state_nxt = RELEASE;
         RELEASE: state_nxt = RUN;
         RUN:     state_nxt = RUN;
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
      // start beats everything, including a transfer in the same cycle
      if (start)
         state_nxt = BOOT_ENTRY;
   end

   // start reloads the counters with zero, which doubles as their clear
   assign i_load = start | ((state == HDR_I) & xfer);
   assign i_n    = start ? '0 : ld_data[IMEM_AW:0];
   assign i_dec  = ~start & (state == LOAD_I) & xfer;
   assign d_load = start | ((state == HDR_D) & xfer);
   assign d_n    = start ? '0 : ld_data[DMEM_AW:0];
   assign d_dec  = ~start & (state == LOAD_D) & xfer;

   boot_beat_cnt #(.AW(IMEM_AW)) u_cnt_i (
      .clk  (clk),
      .rst  (rst),
      .load (i_load),
      .n    (i_n),
      .dec  (i_dec),
      .addr (i_addr),
      .last (i_last)
   );

   boot_beat_cnt #(.AW(DMEM_AW)) u_cnt_d (
      .clk  (clk),
      .rst  (rst),
      .load (d_load),
      .n    (d_n),
      .dec  (d_dec),
      .addr (d_addr),
      .last (d_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ld_ready  <= 1'b0;
         imem_we   <= 1'b0;
         imem_addr <= '0;
         dmem_we   <= 1'b0;
         dmem_addr <= '0;
         rf_we     <= 1'b0;
         rf_addr   <= '0;
         wdata     <= '0;
         cpu_rst   <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state    <= state_nxt;
         ld_ready <= state_nxt inside {HDR_I, LOAD_I, HDR_D, LOAD_D};
         busy     <= state_nxt inside {CLR_RF, HDR_I, LOAD_I, HDR_D, LOAD_D, RELEASE};
         done     <= (state_nxt == RUN);
         err      <= (state_nxt == ERR);
         cpu_rst  <= (state_nxt != RUN);
         imem_we  <= 1'b0;
         dmem_we  <= 1'b0;
         rf_we    <= 1'b0;
         if (start) begin
            imem_addr <= '0;
            dmem_addr <= '0;
            wdata     <= '0;
            rf_we     <= RF_CLEAR;
            rf_addr   <= RF_CLEAR ? 5'd1 : 5'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (state_nxt == CLR_RF) begin
                     rf_we   <= 1'b1;
                     rf_addr <= 5'd1;
                     wdata   <= '0;
                  end
               end
               CLR_RF: begin
                  if (rf_addr != RF_LAST) begin
                     rf_we   <= 1'b1;
                     rf_addr <= rf_addr + 5'd1;
                  end
               end
               LOAD_I: begin
                  if (xfer) begin
                     imem_we   <= 1'b1;
                     imem_addr <= i_addr;
                     wdata     <= ld_data;
                  end
               end
               LOAD_D: begin
                  if (xfer) begin
                     dmem_we   <= 1'b1;
                     dmem_addr <= d_addr;
                     wdata     <= ld_data;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: images are parsed by a list-level model into expected
// write streams, which are compared against the writes the DUT actually issues.
module tb_boot_sequencer;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic        start    = 1'b0;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_data  = '0;
   logic        ld_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic        dmem_we;
   logic [7:0]  dmem_addr;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;

   boot_sequencer #(
      .IMEM_AW  (8),
      .DMEM_AW  (8),
      .RF_CLEAR (1'b1),
      .AUTOBOOT (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .dmem_we   (dmem_we),
      .dmem_addr (dmem_addr),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .wdata     (wdata),
      .cpu_rst   (cpu_rst),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int          n_tot  = 0;
   int          n_bad  = 0;
   int          cyc    = 0;
   int          live_wr = 0;
   logic [39:0] obs_i[$];
   logic [39:0] obs_d[$];
   logic [39:0] obs_rf[$];
   int          obs_i_cyc[$];
   logic [39:0] exp_i[$];
   logic [39:0] exp_d[$];
   logic [31:0] img[$];
   logic        exp_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tot++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] outs();
      return {3'b0, ld_ready, imem_we, imem_addr, dmem_we, dmem_addr, rf_we, rf_addr,
              wdata, cpu_rst, busy, done, err};
   endfunction

   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst) begin
         if (imem_we) begin
            obs_i.push_back({imem_addr, wdata});
            obs_i_cyc.push_back(cyc);
         end
         if (dmem_we) obs_d.push_back({dmem_addr, wdata});
         if (rf_we)   obs_rf.push_back({3'b0, rf_addr, wdata});
         if ((imem_we || dmem_we || rf_we) && !cpu_rst) live_wr++;
      end
   end

   task automatic clear_obs();
      obs_i.delete();
      obs_d.delete();
      obs_rf.delete();
      obs_i_cyc.delete();
      live_wr = 0;
   endtask

   task automatic build(input logic [31:0] hi, input logic [31:0] hd);
      img.delete();
      img.push_back(hi);
      if (hi > 256) return;
      for (int k = 0; k < int'(hi); k++) img.push_back($urandom);
      img.push_back(hd);
      if (hd > 256) return;
      for (int k = 0; k < int'(hd); k++) img.push_back($urandom);
   endtask

   // Reads the image as a list: count, words, count, words.
   task automatic model();
      int          p = 0;
      logic [31:0] n;
      exp_i.delete();
      exp_d.delete();
      exp_err = 1'b0;
      n = img[p++];
      if (n > 256) begin exp_err = 1'b1; return; end
      for (int k = 0; k < int'(n); k++) exp_i.push_back({8'(k), img[p++]});
      n = img[p++];
      if (n > 256) begin exp_err = 1'b1; return; end
      for (int k = 0; k < int'(n); k++) exp_d.push_back({8'(k), img[p++]});
   endtask

   // pct < 0 selects a strict 1,0,1,0 valid pattern.
   task automatic run_image(input int pct, input int budget);
      int   idx = 0;
      int   n   = 0;
      logic rdy;
      while (idx < img.size() && n < budget) begin
         @(negedge clk);
         if (pct < 0) ld_valid = (n % 2 == 0);
         else         ld_valid = ($urandom_range(99) < pct);
         ld_data = img[idx];
         rdy     = ld_ready;
         @(posedge clk);
         if (ld_valid && rdy) idx++;
         n++;
      end
      @(negedge clk);
      ld_valid = 1'b0;
      ld_data  = $urandom;
      chk("image_consumed", idx, img.size());
   endtask

   task automatic finish_check();
      int w = 0;
      model();
      while (!(done || err) && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("end_state_reached", done || err, 1);
      chk("err", err, exp_err);
      chk("done", done, !exp_err);
      chk("cpu_rst", cpu_rst, exp_err);
      chk("busy", busy, 0);
      chk("ld_ready", ld_ready, 0);
      chk("imem_count", obs_i.size(), exp_i.size());
      for (int k = 0; k < exp_i.size() && k < obs_i.size(); k++)
         chk("imem_write", obs_i[k], exp_i[k]);
      chk("dmem_count", obs_d.size(), exp_d.size());
      for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++)
         chk("dmem_write", obs_d[k], exp_d[k]);
      chk("rf_count", obs_rf.size(), 31);
      for (int k = 0; k < 31 && k < obs_rf.size(); k++)
         chk("rf_write", obs_rf[k], {3'b0, 5'(k + 1), 32'h0});
      chk("write_while_running", live_wr, 0);
   endtask

   task automatic pulse_start(input bit with_word);
      @(negedge clk);
      clear_obs();
      start    = 1'b1;
      ld_valid = with_word;
      ld_data  = 32'h1234_5678;
      @(negedge clk);
      start    = 1'b0;
      ld_valid = 1'b0;
      chk("start_cpu_rst", cpu_rst, 1);
      chk("start_rf_addr", rf_addr, 1);
      chk("start_rf_we", rf_we, 1);
      chk("start_done", done, 0);
      chk("start_err", err, 0);
      chk("start_no_imem_we", imem_we, 0);
   endtask

   task automatic load_t1_image();
      img = '{32'd2, 32'h0050_0093, 32'h00A0_0113, 32'd1, 32'hDEAD_BEEF};
   endtask

   initial begin
      logic [31:0] hi;
      logic [31:0] hd;

      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 64'h8);

      // autoboot with the reference image, valid held high
      clear_obs();
      rst = 1'b1;
      load_t1_image();
      run_image(100, 200);
      finish_check();

      // start while running, with a word offered in the same cycle
      pulse_start(1'b1);
      img = '{32'd4, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004,
              32'd2, 32'h2222_0001, 32'h2222_0002};
      run_image(-1, 300);
      finish_check();

      // oversize IMEM header, then recovery with a legal image
      pulse_start(1'b0);
      build(32'h101, 32'd0);
      run_image(100, 100);
      finish_check();
      pulse_start(1'b0);
      load_t1_image();
      run_image(100, 200);
      finish_check();

      // IMEM filled exactly, no DMEM words
      pulse_start(1'b0);
      build(32'd256, 32'd0);
      run_image(100, 600);
      finish_check();
      if (obs_i_cyc.size() == 256)
         chk("imem_burst_span", obs_i_cyc[255] - obs_i_cyc[0], 255);

      // DMEM filled exactly, no IMEM words
      pulse_start(1'b0);
      build(32'd0, 32'd256);
      run_image(100, 600);
      finish_check();

      // randomized images and valid density, some with oversize headers
      for (int r = 0; r < 8; r++) begin
         hi = $urandom_range(12);
         hd = $urandom_range(12);
         case ($urandom_range(3))
            0: hi = 32'd257 + $urandom_range(1000);
            1: hd = 32'd257 + $urandom_range(1000);
            default: ;
         endcase
         pulse_start(1'b0);
         build(hi, hd);
         run_image($urandom_range(20, 100), 2000);
         finish_check();
      end

      // reset while waiting for DMEM word 3
      pulse_start(1'b0);
      build(32'd1, 32'd6);
      while (img.size() > 6) img.pop_back();
      run_image(100, 200);
      chk("mid_load_dmem_writes", obs_d.size(), 3);
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_outputs", outs(), 64'h8);
      @(negedge clk);
      clear_obs();
      rst = 1'b1;
      @(posedge clk);
      #2;
      chk("reboot_rf_we", rf_we, 1);
      chk("reboot_rf_addr", rf_addr, 1);
      chk("reboot_busy", busy, 1);
      chk("reboot_cpu_rst", cpu_rst, 1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
